// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Purpose  : Round-robin arbiter feeding the write side of an async FIFO.
//             Optional packet locking is enabled by FIFO_ARB_PKT_LOCK_EN.
//  Revision : 1.0
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 32
) (
    input  logic               wclk,
    input  logic               wrst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    tail,
    input  logic [NREQ*DW-1:0] din,
    input  logic               wfull,
    output logic [NREQ-1:0]    gnt,
    output logic               winc,
    output logic [DW-1:0]      wdata,
    output logic [1:0]         owner,
    output logic               locked,
    output logic [15:0]        wcount
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [15:0]     wcount_q, wcount_d;

    logic [IW-1:0]   w_win_idx;
    logic [NREQ-1:0] w_mask;
    logic [NREQ-1:0] w_req_hi;
    logic [NREQ-1:0] w_gnt;
    logic            w_lock_active;
    logic            w_accept;

`ifdef FIFO_ARB_PKT_LOCK_EN
    assign w_lock_active = (state_q == LOCK);
`else
    logic w_unused_tail;
    assign w_lock_active = 1'b0;
    assign w_unused_tail = ^tail;
`endif

    // Requesters above last_grant are searched first; wrap to the full vector if none.
    always_comb begin
        w_mask    = '0;
        w_gnt     = '0;
        w_win_idx = owner_q;
        for (int i = 0; i < NREQ; i++) begin
            w_mask[i] = (i > int'(last_q));
        end
        w_req_hi = req & w_mask;
        if (!wrst && !wfull) begin
            if (w_lock_active) begin
                if (req[owner_q]) begin
                    w_gnt[owner_q] = 1'b1;
                end
            end else if (|req) begin
                for (int i = NREQ - 1; i >= 0; i--) begin
                    if (|w_req_hi) begin
                        if (w_req_hi[i]) w_win_idx = IW'(i);
                    end else begin
                        if (req[i]) w_win_idx = IW'(i);
                    end
                end
                w_gnt[w_win_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win_idx == IW'(i)) wdata = din[i*DW +: DW];
        end
    end

    assign w_accept = |w_gnt;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        wcount_d = wcount_q;
        if (w_accept) begin
            last_d   = w_win_idx;
            owner_d  = w_win_idx;
            wcount_d = wcount_q + 16'd1;
`ifdef FIFO_ARB_PKT_LOCK_EN
            if (state_q == IDLE && !tail[w_win_idx]) begin
                state_d = LOCK;
            end else if (state_q == LOCK && tail[w_win_idx]) begin
                state_d = IDLE;
            end
`endif
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q  <= IDLE;
            last_q   <= IW'(NREQ - 1);
            owner_q  <= '0;
            wcount_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            wcount_q <= wcount_d;
        end
    end

    assign gnt    = w_gnt;
    assign winc   = w_accept;
    assign owner  = 2'(owner_q);
    assign locked = (state_q == LOCK);
    assign wcount = wcount_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wr_arbiter
//  Purpose  : Directed self-checking bench for fifo_wr_arbiter (either build
//             of FIFO_ARB_PKT_LOCK_EN).
//  Revision : 1.0
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;

    logic               wclk = 1'b0;
    logic               wrst;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    tail;
    logic [NREQ*DW-1:0] din;
    logic               wfull;
    logic [NREQ-1:0]    gnt;
    logic               winc;
    logic [DW-1:0]      wdata;
    logic [1:0]         owner;
    logic               locked;
    logic [15:0]        wcount;

    int checks = 0;
    int errors = 0;

`ifdef FIFO_ARB_PKT_LOCK_EN
    localparam logic LOCK_EN = 1'b1;
`else
    localparam logic LOCK_EN = 1'b0;
`endif

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .wclk   (wclk),
        .wrst   (wrst),
        .req    (req),
        .tail   (tail),
        .din    (din),
        .wfull  (wfull),
        .gnt    (gnt),
        .winc   (winc),
        .wdata  (wdata),
        .owner  (owner),
        .locked (locked),
        .wcount (wcount)
    );

    always #5 wclk = ~wclk;

    function automatic logic [DW-1:0] lane(input int i);
        return 32'hD000_0000 + 32'(i);
    endfunction

    task automatic do_reset();
        wrst = 1'b1; req = '0; tail = '0; wfull = 1'b0;
        @(posedge wclk); #2;
        wrst = 1'b0;
        @(posedge wclk); #1;
    endtask

    task automatic test_reset();
        wrst = 1'b1; req = 4'b1111; tail = 4'b1111; wfull = 1'b0;
        #3;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
        checks++; if (winc !== 1'b0) begin errors++; $display("FAIL reset_winc got %b exp 0", winc); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", locked); end
        checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d exp 0", owner); end
        checks++; if (wcount !== 16'd0) begin errors++; $display("FAIL reset_wcount got %0d exp 0", wcount); end
        @(posedge wclk); #2;
        wrst = 1'b0; req = '0;
        @(posedge wclk); #1;
    endtask

    task automatic test_round_robin();
        req = 4'b1111; tail = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (gnt !== 4'(1 << k)) begin errors++; $display("FAIL rr_gnt[%0d] got %b exp %b", k, gnt, 4'(1 << k)); end
            checks++; if (winc !== 1'b1) begin errors++; $display("FAIL rr_winc[%0d] got %b exp 1", k, winc); end
            checks++; if (wdata !== lane(k)) begin errors++; $display("FAIL rr_wdata[%0d] got %h exp %h", k, wdata, lane(k)); end
            @(posedge wclk); #1;
        end
        checks++; if (wcount !== 16'd4) begin errors++; $display("FAIL rr_wcount got %0d exp 4", wcount); end
        checks++; if (owner !== 2'd3) begin errors++; $display("FAIL rr_owner got %0d exp 3", owner); end
        req = 4'b0000; #1;
        checks++; if (gnt !== 4'b0000 || winc !== 1'b0) begin errors++; $display("FAIL idle_gnt got %b/%b exp 0000/0", gnt, winc); end
        @(posedge wclk); #1;
        checks++; if (wcount !== 16'd4) begin errors++; $display("FAIL idle_wcount got %0d exp 4", wcount); end
    endtask

    task automatic test_packet_lock();
        logic [3:0] t_tail [4];
        logic [3:0] e_gnt  [4];
        logic       e_lk   [4];
        t_tail = '{4'b1011, 4'b1011, 4'b1111, 4'b1111};
        if (LOCK_EN) begin
            e_gnt = '{4'b0100, 4'b0100, 4'b0100, 4'b1000};
            e_lk  = '{1'b1, 1'b1, 1'b0, 1'b0};
        end else begin
            e_gnt = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
            e_lk  = '{1'b0, 1'b0, 1'b0, 1'b0};
        end
        do_reset();
        req = 4'b0010; tail = 4'b1111; #1;
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL pkt_pre_gnt got %b exp 0010", gnt); end
        @(posedge wclk); #1;
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tail = t_tail[k]; #1;
            checks++; if (gnt !== e_gnt[k]) begin errors++; $display("FAIL pkt_gnt[%0d] got %b exp %b", k, gnt, e_gnt[k]); end
            @(posedge wclk); #1;
            checks++; if (locked !== e_lk[k]) begin errors++; $display("FAIL pkt_locked[%0d] got %b exp %b", k, locked, e_lk[k]); end
        end
        checks++; if (wcount !== 16'd5) begin errors++; $display("FAIL pkt_wcount got %0d exp 5", wcount); end
    endtask

    task automatic test_owner_drop();
        logic [3:0] e_gnt;
        e_gnt = LOCK_EN ? 4'b0000 : 4'b0010;
        do_reset();
        req = 4'b0001; tail = 4'b0000; #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL drop_first_gnt got %b exp 0001", gnt); end
        @(posedge wclk); #1;
        req = 4'b1110; #1;
        checks++; if (gnt !== e_gnt) begin errors++; $display("FAIL drop_gnt got %b exp %b", gnt, e_gnt); end
        @(posedge wclk); #1;
        checks++; if (locked !== LOCK_EN) begin errors++; $display("FAIL drop_locked got %b exp %b", locked, LOCK_EN); end
    endtask

    task automatic test_wfull();
        do_reset();
        req = 4'b0011; tail = 4'b1111; wfull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (gnt !== 4'b0000 || winc !== 1'b0) begin errors++; $display("FAIL full_gnt[%0d] got %b/%b exp 0000/0", k, gnt, winc); end
            @(posedge wclk); #1;
        end
        checks++; if (wcount !== 16'd0) begin errors++; $display("FAIL full_wcount got %0d exp 0", wcount); end
        checks++; if (wdata !== lane(0)) begin errors++; $display("FAIL full_wdata got %h exp %h", wdata, lane(0)); end
        wfull = 1'b0; #1;
        checks++; if (gnt !== 4'b0001 || winc !== 1'b1) begin errors++; $display("FAIL unfull_gnt got %b/%b exp 0001/1", gnt, winc); end
        @(posedge wclk); #1;
        checks++; if (wcount !== 16'd1) begin errors++; $display("FAIL unfull_wcount got %0d exp 1", wcount); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        req = 4'b0010; tail = 4'b0000;
        @(posedge wclk); #1;
        checks++; if (owner !== 2'd1 || locked !== LOCK_EN) begin errors++; $display("FAIL mid_pre got owner %0d locked %b exp 1/%b", owner, locked, LOCK_EN); end
        #2; wrst = 1'b1; #1;
        checks++; if (locked !== 1'b0 || owner !== 2'd0) begin errors++; $display("FAIL mid_rst got owner %0d locked %b exp 0/0", owner, locked); end
        checks++; if (wcount !== 16'd0 || gnt !== 4'b0000) begin errors++; $display("FAIL mid_rst_cnt got wcount %0d gnt %b exp 0/0000", wcount, gnt); end
        #1; wrst = 1'b0; req = 4'b0011; tail = 4'b1111; #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_after_gnt got %b exp 0001", gnt); end
        @(posedge wclk); #1;
        checks++; if (wcount !== 16'd1 || owner !== 2'd0) begin errors++; $display("FAIL mid_after got wcount %0d owner %0d exp 1/0", wcount, owner); end
    endtask

    task automatic test_wrap();
        do_reset();
        req = 4'b0001; tail = 4'b1111;
        repeat (65535) @(posedge wclk);
        #1;
        checks++; if (wcount !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre got %h exp ffff", wcount); end
        @(posedge wclk); #1;
        checks++; if (wcount !== 16'h0000) begin errors++; $display("FAIL wrap got %h exp 0000", wcount); end
        req = '0;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) din[i*DW +: DW] = lane(i);
        wrst = 1'b1; req = '0; tail = '0; wfull = 1'b0;
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_owner_drop();
        test_wfull();
        test_reset_mid_packet();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
